// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, issues word fetches to instruction memory, applies redirects
// from later stages and presents {if_pc, if_instr, if_valid} to decode.
//
// Memory handshake: imem_req/imem_addr stay stable from the cycle a request
// is raised until the cycle imem_ready is seen high; a request completes
// exactly in a cycle where imem_req && imem_ready, and imem_rdata is only
// meaningful in that cycle. A raised request is never withdrawn early.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] IRQ_PC    = 32'h8000_0004,
    parameter logic [31:0] EXP_PC    = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redir_exp,
    input  logic        redir_irq,
    input  logic        redir_jr,
    input  logic [31:0] jr_target,
    input  logic        redir_jump,
    input  logic [31:0] jump_target,
    input  logic        redir_branch,
    input  logic [31:0] branch_target,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        pc_super,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        armed_q, armed_d;

    logic        redir_any;
    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic        accept;

    // Low address bits of the targets are forced to zero, so they are never read.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^{jr_target[1:0], jump_target[1:0], branch_target[1:0]};

    // armed_q keeps the request low for the first cycle after reset release.
    assign imem_req  = armed_q && (state_q != S_HOLD);
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;
    assign pc_plus4  = pc_q + 32'd4;

    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_valid  = if_valid_q;
    assign pc_super  = if_pc_q[31];
    assign dbg_state = state_q;

    // Pick the single highest-priority redirect; jr may never raise pc[31].
    always_comb begin
        redir_any = redir_exp | redir_irq | redir_jr | redir_jump | redir_branch;
        redir_tgt = {branch_target[31:2], 2'b00};
        if (redir_exp) begin
            redir_tgt = {1'b1, EXP_PC[30:2], 2'b00};
        end else if (redir_irq) begin
            redir_tgt = {1'b1, IRQ_PC[30:2], 2'b00};
        end else if (redir_jr) begin
            redir_tgt = {jr_target[31] & pc_q[31], jr_target[30:2], 2'b00};
        end else if (redir_jump) begin
            redir_tgt = {jump_target[31:2], 2'b00};
        end
    end

    // Next-state, PC and IF/ID update. IF/ID takes a bubble on any unstalled
    // cycle that does not deliver a real instruction; flush overrides all.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        buf_d      = buf_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        armed_d    = 1'b1;

        if (!stall) begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (redir_any) begin
                    if (accept || !imem_req) begin
                        pc_d = redir_tgt;
                    end else begin
                        // Request cannot be aborted: wait for its data, then go.
                        pend_d  = redir_tgt;
                        state_d = S_DRAIN;
                    end
                end else if (accept && !flush) begin
                    if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        if_pc_d    = pc_plus4;
                        if_instr_d = imem_rdata;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus4;
                    end
                end
            end
            S_HOLD: begin
                if (redir_any) begin
                    pc_d    = redir_tgt;
                    state_d = S_FETCH;
                end else if (flush) begin
                    // Buffered word is wrong-path; refetch from the same pc.
                    state_d = S_FETCH;
                end else if (!stall) begin
                    if_pc_d    = pc_plus4;
                    if_instr_d = buf_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_plus4;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    pc_d    = redir_any ? redir_tgt : pend_q;
                    state_d = S_FETCH;
                end else if (redir_any) begin
                    pend_d = redir_tgt;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (flush) begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end
    end

    // State and pipeline registers, asynchronously reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pend_q     <= RESET_PC;
            buf_q      <= NOP_INSTR;
            if_pc_q    <= RESET_PC;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            buf_q      <= buf_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            armed_q    <= armed_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, a fetch-address scoreboard and an
// IF/ID-load scoreboard checked by a monitor on the falling clock edge.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redir_exp;
    logic        redir_irq;
    logic        redir_jr;
    logic [31:0] jr_target;
    logic        redir_jump;
    logic [31:0] jump_target;
    logic        redir_branch;
    logic [31:0] branch_target;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        pc_super;
    logic [1:0]  dbg_state;

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .redir_exp     (redir_exp),
        .redir_irq     (redir_irq),
        .redir_jr      (redir_jr),
        .jr_target     (jr_target),
        .redir_jump    (redir_jump),
        .jump_target   (jump_target),
        .redir_branch  (redir_branch),
        .branch_target (branch_target),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_valid      (if_valid),
        .pc_super      (pc_super),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model: each word is its address XOR a fixed pattern.
    always_comb imem_rdata = imem_addr ^ 32'hDEAD_0001;

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_q[$];

    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] pop_addr;
    logic [63:0] pop_load;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push_addr(input logic [31:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic push_load(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // Monitor: every completed fetch and every new IF/ID load is popped and compared.
    always @(negedge clk) begin
        if (imem_req === 1'b1 && imem_ready === 1'b1) begin
            n_cmp++;
            if (exp_addr_q.size() == 0) begin
                n_err++;
                $display("FAIL fetch_addr: unexpected fetch of %h at %0t", imem_addr, $time);
            end else begin
                pop_addr = exp_addr_q.pop_front();
                if (imem_addr !== pop_addr) begin
                    n_err++;
                    $display("FAIL fetch_addr: got %h expected %h at %0t", imem_addr, pop_addr, $time);
                end
            end
        end
        if (if_valid === 1'b1 &&
            (!prev_valid || if_pc !== prev_pc || if_instr !== prev_instr)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ifid_load: unexpected load pc %h instr %h at %0t", if_pc, if_instr, $time);
            end else begin
                pop_load = exp_q.pop_front();
                if ({if_pc, if_instr} !== pop_load) begin
                    n_err++;
                    $display("FAIL ifid_load: got pc %h instr %h expected pc %h instr %h at %0t",
                             if_pc, if_instr, pop_load[63:32], pop_load[31:0], $time);
                end
            end
        end
        prev_valid = (if_valid === 1'b1);
        prev_pc    = if_pc;
        prev_instr = if_instr;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ready    = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        redir_exp     = 1'b0;
        redir_irq     = 1'b0;
        redir_jr      = 1'b0;
        jr_target     = 32'h0;
        redir_jump    = 1'b0;
        jump_target   = 32'h0;
        redir_branch  = 1'b0;
        branch_target = 32'h0;
    endtask

    // Returns at the start of the first cycle in which a request is raised.
    task automatic reset_dut();
        reset = 1'b0;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b1;
        mid();
        chk("req_after_release", {31'b0, imem_req}, 32'h0);
        tick();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        #1 reset = 1'b0;
        #2;
        chk("rst_if_pc", if_pc, 32'h8000_0000);
        chk("rst_if_instr", if_instr, 32'h0000_0000);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_super", {31'b0, pc_super}, 32'h1);

        // A: ready tied high -> back-to-back sequential fetches.
        reset_dut();
        push_addr(32'h8000_0000); push_addr(32'h8000_0004); push_addr(32'h8000_0008);
        push_load(32'h8000_0004, 32'h5EAD_0001);
        push_load(32'h8000_0008, 32'h5EAD_0005);
        push_load(32'h8000_000C, 32'h5EAD_0009);
        imem_ready = 1'b1;
        repeat (3) tick();
        imem_ready = 1'b0;
        mid();
        tick();

        // B: ready delayed three cycles -> address held, exactly one load.
        reset_dut();
        push_addr(32'h8000_0000);
        push_load(32'h8000_0004, 32'h5EAD_0001);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("wait_addr_stable", imem_addr, 32'h8000_0000);
            chk("wait_no_valid", {31'b0, if_valid}, 32'h0);
            tick();
        end
        imem_ready = 1'b1;
        mid();
        chk("ready_addr", imem_addr, 32'h8000_0000);
        tick();
        imem_ready = 1'b0;
        mid();
        tick();
        mid();
        chk("bubble_after_load", {31'b0, if_valid}, 32'h0);
        tick();

        // C: stall across a completing fetch -> skid buffer, released after stall.
        reset_dut();
        push_addr(32'h8000_0000); push_addr(32'h8000_0004);
        push_load(32'h8000_0004, 32'h5EAD_0001);
        push_load(32'h8000_0008, 32'h5EAD_0005);
        imem_ready = 1'b1;
        tick();
        stall = 1'b1;
        tick();
        imem_ready = 1'b0;
        mid();
        chk("stall_if_pc", if_pc, 32'h8000_0004);
        chk("stall_if_instr", if_instr, 32'h5EAD_0001);
        chk("hold_no_req", {31'b0, imem_req}, 32'h0);
        tick();
        stall = 1'b0;
        mid();
        chk("stall_drop_if_instr", if_instr, 32'h5EAD_0001);
        tick();
        mid();
        chk("after_hold_addr", imem_addr, 32'h8000_0008);
        tick();

        // D: priority, supervisor bit rules.
        reset_dut();
        push_addr(32'h8000_0000); push_addr(32'h0000_1000); push_addr(32'h8000_0004);
        push_addr(32'h0000_2000); push_addr(32'h0000_0100);
        push_load(32'h0000_0104, 32'hDEAD_0101);
        imem_ready  = 1'b1;
        redir_jump  = 1'b1;
        jump_target = 32'h0000_1000;
        tick();
        redir_jump    = 1'b0;
        redir_branch  = 1'b1;
        branch_target = 32'h0000_2000;
        redir_irq     = 1'b1;
        tick();
        redir_branch = 1'b0;
        redir_irq    = 1'b0;
        redir_jump   = 1'b1;
        jump_target  = 32'h0000_2000;
        tick();
        redir_jump = 1'b0;
        redir_jr   = 1'b1;
        jr_target  = 32'h8000_0100;
        tick();
        redir_jr = 1'b0;
        mid();
        chk("jr_user_addr", imem_addr, 32'h0000_0100);
        chk("redir_bubble", {31'b0, if_valid}, 32'h0);
        tick();
        imem_ready = 1'b0;
        mid();
        chk("user_super", {31'b0, pc_super}, 32'h0);
        tick();

        // E: redirect with a request outstanding -> drain, later redirect wins.
        reset_dut();
        push_addr(32'h8000_0000); push_addr(32'h8000_0004); push_addr(32'h0000_0040);
        push_load(32'h8000_0004, 32'h5EAD_0001);
        push_load(32'h0000_0044, 32'hDEAD_0041);
        imem_ready = 1'b1;
        tick();
        imem_ready    = 1'b0;
        redir_branch  = 1'b1;
        branch_target = 32'h0000_0300;
        tick();
        redir_branch = 1'b0;
        redir_jump   = 1'b1;
        jump_target  = 32'h0000_0040;
        mid();
        chk("drain_addr", imem_addr, 32'h8000_0004);
        chk("drain_req", {31'b0, imem_req}, 32'h1);
        chk("drain_valid", {31'b0, if_valid}, 32'h0);
        tick();
        redir_jump = 1'b0;
        imem_ready = 1'b1;
        mid();
        chk("drain_ready_addr", imem_addr, 32'h8000_0004);
        tick();
        mid();
        chk("stale_discarded", {31'b0, if_valid}, 32'h0);
        chk("post_drain_addr", imem_addr, 32'h0000_0040);
        tick();
        imem_ready = 1'b0;
        mid();
        tick();

        // G: pc+4 wraps at the top of the address space.
        reset_dut();
        push_addr(32'h8000_0000); push_addr(32'hFFFF_FFFC); push_addr(32'h0000_0000);
        push_load(32'h0000_0000, 32'h2152_FFFD);
        push_load(32'h0000_0004, 32'hDEAD_0001);
        imem_ready  = 1'b1;
        redir_jump  = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        redir_jump = 1'b0;
        tick();
        tick();
        imem_ready = 1'b0;
        mid();
        tick();

        // F: flush together with stall, then reset asserted during HOLD.
        reset_dut();
        push_addr(32'h8000_0000); push_addr(32'h8000_0004); push_addr(32'h8000_0004);
        push_load(32'h8000_0004, 32'h5EAD_0001);
        imem_ready = 1'b1;
        tick();
        stall = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mid();
        chk("flush_if_instr", if_instr, 32'h0000_0000);
        chk("flush_if_valid", {31'b0, if_valid}, 32'h0);
        chk("flush_if_pc", if_pc, 32'h8000_0004);
        tick();
        imem_ready = 1'b0;
        mid();
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        reset = 1'b0;
        #1;
        chk("hold_rst_req", {31'b0, imem_req}, 32'h0);
        chk("hold_rst_addr", imem_addr, 32'h8000_0000);
        chk("hold_rst_if_pc", if_pc, 32'h8000_0000);
        chk("hold_rst_if_instr", if_instr, 32'h0000_0000);
        chk("hold_rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("hold_rst_super", {31'b0, pc_super}, 32'h1);
        stall = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        mid();
        chk("req_after_hold_reset", {31'b0, imem_req}, 32'h0);
        tick();
        push_addr(32'h8000_0000);
        push_load(32'h8000_0004, 32'h5EAD_0001);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        mid();
        tick();
        tick();

        // ---------------- final report ----------------
        chk("addr_queue_empty", exp_addr_q.size(), 32'd0);
        chk("load_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
